// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command bytes, scan FSM encoding and the key-scan bit map.
// Used by both the key scanner and the display driver.
package tm1638_pkg;

    localparam logic [7:0] CMD_READ_KEY   = 8'h42;
    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;

    localparam int CMD_BITS  = 8;
    localparam int READ_BITS = 32;

    // Bit positions inside each scan byte that carry a key; the rest are other matrix rows.
    localparam int KEY_BIT_LO = 0;
    localparam int KEY_BIT_HI = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STB_SETUP = 3'd1,
        ST_CMD       = 3'd2,
        ST_WAIT      = 3'd3,
        ST_READ      = 3'd4,
        ST_STB_END   = 3'd5,
        ST_DONE      = 3'd6
    } scan_state_t;

    function automatic logic [7:0] key_map(input logic [31:0] raw);
        logic [7:0] k;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            k[i]     = raw[8*i + KEY_BIT_LO];
            k[i + 4] = raw[8*i + KEY_BIT_HI];
        end
        return k;
    endfunction

endpackage

// File: rtl/tm1638_shift_io.sv
// Tick-driven two-phase serial bit engine for the TM1638 bus, LSB first.
// Phase 0 drives CLK low with the next tx bit; phase 1 raises CLK and captures DIO at its end.
module tm1638_shift_io (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_start,
    input  logic        i_rx_mode,
    input  logic [4:0]  i_last_bit,
    input  logic [7:0]  i_tx_byte,
    input  logic        i_dio,
    output logic        o_sclk,
    output logic        o_dout,
    output logic        o_oe,
    output logic        o_done,
    output logic [31:0] o_rx_data
);

    logic        r_active;
    logic        r_phase;
    logic        r_rx;
    logic        r_sclk;
    logic        r_dout;
    logic        r_oe;
    logic [4:0]  r_cnt;
    logic [31:0] r_sreg;

    assign o_done    = r_active & r_phase & i_tick & (r_cnt == 5'd0);
    assign o_sclk    = r_sclk;
    assign o_dout    = r_dout;
    assign o_oe      = r_oe;
    assign o_rx_data = r_sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_rx     <= 1'b0;
            r_sclk   <= 1'b1;
            r_dout   <= 1'b1;
            r_oe     <= 1'b0;
            r_cnt    <= '0;
            r_sreg   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_phase  <= 1'b0;
            r_rx     <= i_rx_mode;
            r_sclk   <= 1'b0;
            r_cnt    <= i_last_bit;
            r_sreg   <= {24'd0, i_tx_byte};
            r_dout   <= i_rx_mode ? 1'b1 : i_tx_byte[0];
            r_oe     <= ~i_rx_mode;
        end else if (r_active && i_tick) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
                r_sclk  <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                r_sreg  <= {(r_rx ? i_dio : 1'b0), r_sreg[31:1]};
                if (r_cnt == 5'd0) begin
                    // Last bit: leave CLK high and release DIO so the device can turn the line.
                    r_active <= 1'b0;
                    r_oe     <= 1'b0;
                    r_dout   <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt - 5'd1;
                    r_sclk <= 1'b0;
                    r_dout <= r_rx ? 1'b1 : r_sreg[1];
                end
            end
        end
    end

endmodule

// File: rtl/tm1638_key_scan.sv
// TM1638 key scanner: issues READ-KEY, reads 4 bytes, maps them to 8 keys and debounces
// across consecutive scans, producing a stable bitmap plus one-cycle press edges.
module tm1638_key_scan
    import tm1638_pkg::*;
#(
    parameter int WAIT_TICKS   = 2,
    parameter int STABLE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    output logic       busy,
    output logic       tm_clk,
    output logic       tm_stb,
    output logic       dio_out,
    output logic       dio_oe,
    input  logic       dio_in,
    output logic [7:0] keys,
    output logic [7:0] key_press,
    output logic       scan_done
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_SCANS);

    scan_state_t r_state;
    scan_state_t w_state_next;

    logic [7:0]  r_wait_cnt;
    logic        w_io_start;
    logic        w_io_rx;
    logic        w_io_done;
    logic [4:0]  w_io_last_bit;
    logic [31:0] w_rx_word;

    logic [7:0]  r_keys;
    logic [7:0]  r_key_press;
    logic [7:0]  r_last_raw;
    logic [3:0]  r_stable_cnt;
    logic [7:0]  w_raw_keys;
    logic [3:0]  w_cnt_next;
    logic        w_take;

    assign w_io_last_bit = w_io_rx ? 5'(READ_BITS - 1) : 5'(CMD_BITS - 1);

    tm1638_shift_io u_shift_io (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (tick),
        .i_start    (w_io_start),
        .i_rx_mode  (w_io_rx),
        .i_last_bit (w_io_last_bit),
        .i_tx_byte  (CMD_READ_KEY),
        .i_dio      (dio_in),
        .o_sclk     (tm_clk),
        .o_dout     (dio_out),
        .o_oe       (dio_oe),
        .o_done     (w_io_done),
        .o_rx_data  (w_rx_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_io_start   = 1'b0;
        w_io_rx      = 1'b0;
        case (r_state)
            ST_IDLE:      if (start) w_state_next = ST_STB_SETUP;
            ST_STB_SETUP: if (tick) begin
                              w_state_next = ST_CMD;
                              w_io_start   = 1'b1;
                          end
            ST_CMD:       if (w_io_done) w_state_next = ST_WAIT;
            ST_WAIT:      if (tick && r_wait_cnt == 8'd0) begin
                              w_state_next = ST_READ;
                              w_io_start   = 1'b1;
                              w_io_rx      = 1'b1;
                          end
            ST_READ:      if (w_io_done) w_state_next = ST_STB_END;
            ST_STB_END:   if (tick) w_state_next = ST_DONE;
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b1;
        tm_stb    = 1'b0;
        scan_done = 1'b0;
        case (r_state)
            ST_IDLE:    begin busy = 1'b0; tm_stb = 1'b1; end
            ST_STB_END: tm_stb = 1'b1;
            ST_DONE:    begin tm_stb = 1'b1; scan_done = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_CMD && w_io_done) begin
            r_wait_cnt <= 8'(WAIT_TICKS - 1);
        end else if (r_state == ST_WAIT && tick && r_wait_cnt != 8'd0) begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
        end
    end

    // A scan only reaches the key outputs once STABLE_SCANS consecutive scans agree.
    assign w_raw_keys = key_map(w_rx_word);

    always_comb begin
        if (w_raw_keys == r_last_raw) begin
            w_cnt_next = (r_stable_cnt >= STABLE_LIM) ? STABLE_LIM : r_stable_cnt + 4'd1;
        end else begin
            w_cnt_next = 4'd1;
        end
        w_take = (w_cnt_next >= STABLE_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys       <= '0;
            r_key_press  <= '0;
            r_last_raw   <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_key_press <= '0;
            if (r_state == ST_DONE) begin
                r_stable_cnt <= w_cnt_next;
                r_last_raw   <= w_raw_keys;
                if (w_take) begin
                    r_keys      <= w_raw_keys;
                    r_key_press <= w_raw_keys & ~r_keys;
                end
            end
        end
    end

    assign keys      = r_keys;
    assign key_press = r_key_press;

endmodule

// File: tb/tb_tm1638_key_scan.sv
// Self-checking bench for tm1638_key_scan: bus-level TM1638 device model, table-driven
// scans, randomized scans against a history-based debounce model, and multi-cycle corner cases.
module tb_tm1638_key_scan;

    localparam int TDIV       = 4;
    localparam int S          = 2;
    localparam int SCAN_TICKS = 84;
    localparam int SCAN_LIMIT = 3000;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       tick   = 1'b0;
    logic       start  = 1'b0;
    logic       dio_in = 1'b1;
    logic       busy, tm_clk, tm_stb, dio_out, dio_oe, scan_done;
    logic [7:0] keys, key_press;

    tm1638_key_scan #(.WAIT_TICKS(2), .STABLE_SCANS(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .busy      (busy),
        .tm_clk    (tm_clk),
        .tm_stb    (tm_stb),
        .dio_out   (dio_out),
        .dio_oe    (dio_oe),
        .dio_in    (dio_in),
        .keys      (keys),
        .key_press (key_press),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(negedge clk) begin
        tdiv = (tdiv == TDIV - 1) ? 0 : tdiv + 1;
        tick = (tdiv == 0);
    end

    // Ticks seen since the last accepted start (start is accepted only while not busy).
    int tick_cnt = 0;
    always @(posedge clk) begin
        if (start && !busy) tick_cnt <= 0;
        else if (tick)      tick_cnt <= tick_cnt + 1;
    end

    // TM1638 device model, sampled mid-cycle: records the command, then answers with resp_word.
    logic [31:0] resp_word = '0;
    logic [7:0]  cmd_byte  = '0;
    int          bus_bits  = 0;
    int          oe_bad    = 0;
    logic        prev_stb  = 1'b1;
    logic        prev_clk  = 1'b1;
    always @(negedge clk) begin
        if (prev_stb === 1'b1 && tm_stb === 1'b0) begin
            bus_bits = 0;
            cmd_byte = '0;
            oe_bad   = 0;
        end
        if (prev_stb === 1'b0 && tm_stb === 1'b1) dio_in = 1'b1;
        if (tm_stb === 1'b0 && prev_clk === 1'b0 && tm_clk === 1'b1) begin
            if (bus_bits < 8) begin
                cmd_byte[bus_bits[2:0]] = dio_out;
                if (dio_oe !== 1'b1) oe_bad++;
            end else if (dio_oe !== 1'b0) begin
                oe_bad++;
            end
            bus_bits++;
        end
        if (tm_stb === 1'b0 && prev_clk === 1'b1 && tm_clk === 1'b0 && bus_bits >= 8 && bus_bits < 40)
            dio_in = resp_word[5'(bus_bits - 8)];
        prev_stb = tm_stb;
        prev_clk = tm_clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else             n_pass++;
    endtask

    // Reference model: keys take a scan's value once the last S scans since reset are identical.
    logic [7:0] hist_q[$];
    logic [7:0] m_keys  = '0;
    logic [7:0] m_press = '0;

    function automatic logic [7:0] raw_keys(input logic [31:0] w);
        logic [7:0] k = '0;
        for (int i = 0; i < 4; i++) begin
            if (((w >> (8*i)) & 32'd1) != 0)     k = k | 8'(1 << i);
            if (((w >> (8*i + 4)) & 32'd1) != 0) k = k | 8'(1 << (i + 4));
        end
        return k;
    endfunction

    task automatic model_reset();
        hist_q.delete();
        m_keys  = '0;
        m_press = '0;
    endtask

    task automatic model_push(input logic [31:0] w);
        logic [7:0] r;
        logic       same;
        r = raw_keys(w);
        hist_q.push_back(r);
        if (hist_q.size() > S) void'(hist_q.pop_front());
        same = (hist_q.size() == S);
        foreach (hist_q[j]) if (hist_q[j] != r) same = 1'b0;
        m_press = '0;
        if (same) begin
            m_press = r & ~m_keys;
            m_keys  = r;
        end
    endtask

    task automatic run_scan(input logic [31:0] resp, output logic [7:0] k, output logic [7:0] p);
        int n = 0;
        resp_word = resp;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (scan_done !== 1'b1 && n < SCAN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("scan_timeout", 32'(n < SCAN_LIMIT), 32'd1);
        check("latency_ticks", tick_cnt, SCAN_TICKS);
        check("cmd_byte", cmd_byte, 32'h42);
        check("clk_rises", bus_bits, 40);
        check("dio_oe_phase", oe_bad, 0);
        model_push(resp);
        @(negedge clk);
        k = keys;
        p = key_press;
        check("busy_after_done", busy, 1'b0);
        @(negedge clk);
        check("press_one_cycle", key_press, 8'h00);
        $display("scan resp=%08h keys=%02h press=%02h ticks=%0d", resp, k, p, tick_cnt);
    endtask

    typedef struct {
        logic [31:0] resp;
        logic [7:0]  exp_keys;
        logic [7:0]  exp_press;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0]  k, p;
        logic [31:0] resp, prev_resp;
        int          bad, n, done_cnt, low_run, gap_cnt, gap_min, gap_max;
        logic        seen_busy;

        vecs[0] = '{32'h0000_1001, 8'h00, 8'h00};
        vecs[1] = '{32'h0000_1001, 8'h21, 8'h21};
        vecs[2] = '{32'h0000_0001, 8'h21, 8'h00};
        vecs[3] = '{32'h0000_0000, 8'h21, 8'h00};
        vecs[4] = '{32'h0000_0001, 8'h21, 8'h00};
        vecs[5] = '{32'h0000_0001, 8'h01, 8'h00};
        vecs[6] = '{32'hEEEE_EEEE, 8'h01, 8'h00};
        vecs[7] = '{32'hEEEE_EEEE, 8'h00, 8'h00};
        vecs[8] = '{32'h1111_1111, 8'h00, 8'h00};
        vecs[9] = '{32'h1111_1111, 8'hFF, 8'hFF};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tm_stb", tm_stb, 1'b1);
        check("rst_tm_clk", tm_clk, 1'b1);
        check("rst_dio_oe", dio_oe, 1'b0);
        check("rst_dio_out", dio_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_keys", keys, 8'h00);
        check("rst_key_press", key_press, 8'h00);
        check("rst_scan_done", scan_done, 1'b0);
        rst = 1'b0;
        model_reset();

        // Quiet bus with no start for 100 ticks
        bad = 0;
        repeat (100 * TDIV) begin
            @(negedge clk);
            if (tm_stb !== 1'b1 || tm_clk !== 1'b1 || dio_oe !== 1'b0 || keys !== 8'h00 || busy !== 1'b0)
                bad++;
        end
        check("idle_quiet", bad, 0);

        // Table-driven scans: key map, debounce, bounce rejection, ignored bits
        for (int i = 0; i < 10; i++) begin
            run_scan(vecs[i].resp, k, p);
            check("tbl_keys", k, vecs[i].exp_keys);
            check("tbl_press", p, vecs[i].exp_press);
        end

        // Randomized scans with frequent repeats so the debounce actually fires
        prev_resp = 32'h0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0 && $urandom_range(2, 0) != 0) resp = prev_resp;
            else                                    resp = $urandom;
            prev_resp = resp;
            run_scan(resp, k, p);
            check("rnd_keys", k, m_keys);
            check("rnd_press", p, m_press);
        end

        // start held high: three back-to-back scans, exactly one idle cycle between them
        resp_word = 32'h0000_0001;
        @(negedge clk); start = 1'b1;
        done_cnt = 0; n = 0; low_run = 0; gap_cnt = 0; gap_min = 999; gap_max = 0; seen_busy = 1'b0;
        while (done_cnt < 3 && n < 3 * SCAN_LIMIT) begin
            @(negedge clk);
            n++;
            if (busy) begin
                if (seen_busy && low_run > 0) begin
                    gap_cnt++;
                    if (low_run < gap_min) gap_min = low_run;
                    if (low_run > gap_max) gap_max = low_run;
                end
                low_run   = 0;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                low_run++;
            end
            if (scan_done) begin
                done_cnt++;
                model_push(resp_word);
                if (done_cnt == 3) start = 1'b0;
            end
        end
        check("held_scans", done_cnt, 3);
        check("held_gap_count", gap_cnt, 2);
        check("held_gap_min", gap_min, 1);
        check("held_gap_max", gap_max, 1);
        repeat (3) @(negedge clk);
        check("held_stops", busy, 1'b0);
        check("held_keys", keys, m_keys);
        $display("held start: scans=%0d gaps=%0d keys=%02h", done_cnt, gap_cnt, keys);

        // A start pulse during busy is dropped, not queued
        resp_word = 32'h0000_0010;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (scan_done !== 1'b1 && n < SCAN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("noq_timeout", 32'(n < SCAN_LIMIT), 32'd1);
        model_push(resp_word);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        check("no_queue", bad, 0);
        check("noq_keys", keys, m_keys);
        $display("busy start pulse: busy cycles after scan=%0d", bad);

        // Reset in the middle of READ discards everything; next scan is clean
        run_scan(32'h1111_1111, k, p);
        run_scan(32'h1111_1111, k, p);
        check("pre_rst_keys", k, 8'hFF);
        resp_word = 32'h0000_1001;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (bus_bits < 20 && n < SCAN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("midread_reached", 32'(n < SCAN_LIMIT), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tm_stb", tm_stb, 1'b1);
        check("mid_rst_tm_clk", tm_clk, 1'b1);
        check("mid_rst_dio_oe", dio_oe, 1'b0);
        check("mid_rst_keys", keys, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        model_reset();
        $display("reset mid-read at bit %0d", bus_bits - 8);
        run_scan(32'h0000_1001, k, p);
        check("post_rst_keys1", k, m_keys);
        run_scan(32'h0000_1001, k, p);
        check("post_rst_keys2", k, m_keys);
        check("post_rst_press2", p, m_press);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
